// File: rtl/eq_axis_frame_formatter.sv
// Reformats the equalized 2*DATA_WIDTH stream into a DATA_WIDTH pixel stream with
// regenerated tuser/tlast framing, a 2-entry skid buffer and sticky framing error flags.
module eq_axis_frame_formatter #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 1024
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_reset,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    input  logic                    i_err_clear,
    output logic                    o_err_line,
    output logic                    o_err_frame,
    output logic                    o_frame_done,
    output logic [15:0]             o_frame_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int BW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {
        ST_SYNC,
        ST_ACTIVE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] col, col_next;
    logic [RW-1:0] row, row_next;

    // Skid entries hold {tuser, tlast, pixel}; slot0 is always the head.
    logic [BW-1:0] slot0, slot1;
    logic [1:0]    count;

    logic          accept, pop, push;
    logic          fwd, fwd_user, fwd_last;
    logic          set_line, set_frame, done_next;
    logic          at_eol;
    logic [BW-1:0] fwd_entry;
    logic          unused_low;

    assign unused_low    = ^s_axis_tdata[DATA_WIDTH-1:0];

    assign s_axis_tready = ~i_sys_reset & (count != 2'd2);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = (count != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = accept & fwd;
    assign m_axis_tuser  = slot0[BW-1];
    assign m_axis_tlast  = slot0[BW-2];
    assign m_axis_tdata  = slot0[DATA_WIDTH-1:0];
    assign at_eol        = (col == COL_LAST);
    assign fwd_entry     = {fwd_user, fwd_last, s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH]};

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state <= ST_SYNC;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        fwd        = 1'b0;
        fwd_user   = 1'b0;
        fwd_last   = 1'b0;
        set_line   = 1'b0;
        set_frame  = 1'b0;
        done_next  = 1'b0;
        if (accept) begin
            unique case (state)
                ST_SYNC: begin
                    if (s_axis_tuser) begin
                        fwd        = 1'b1;
                        fwd_user   = 1'b1;
                        col_next   = CW'(1);
                        row_next   = '0;
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // A stray SOF restarts the frame and outranks a tlast mismatch.
                    if (s_axis_tuser) begin
                        set_frame = 1'b1;
                        fwd       = 1'b1;
                        fwd_user  = 1'b1;
                        col_next  = CW'(1);
                        row_next  = '0;
                    end else if (s_axis_tlast != at_eol) begin
                        set_line   = 1'b1;
                        col_next   = '0;
                        row_next   = '0;
                        state_next = ST_SYNC;
                    end else begin
                        fwd      = 1'b1;
                        fwd_last = at_eol;
                        if (at_eol) begin
                            col_next = '0;
                            if (row == ROW_LAST) begin
                                row_next   = '0;
                                done_next  = 1'b1;
                                state_next = ST_SYNC;
                            end else begin
                                row_next = row + RW'(1);
                            end
                        end else begin
                            col_next = col + CW'(1);
                        end
                    end
                end
                default: state_next = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= fwd_entry;
                    else               slot1 <= fwd_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= fwd_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fwd_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            o_err_line   <= 1'b0;
            o_err_frame  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
        end else begin
            o_err_line   <= set_line | (o_err_line & ~i_err_clear);
            o_err_frame  <= set_frame | (o_err_frame & ~i_err_clear);
            o_frame_done <= done_next;
            if (done_next) o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

endmodule
